// File: rtl/axil_host_master_if.sv
// AXI4-Lite master-side bus bundle used by axil_host_master.
// Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
// R (rdata/rresp/rvalid/rready).
// The master modport drives addresses, data and valids and owns bready/rready.
// The slave modport is the mirror image.
interface axil_host_master_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_host_master.sv
// Host-side register master: turns single-word commands into AXI4-Lite
// transactions (with a per-transaction timeout), and also hosts a small GPIO
// block and an AXI-Stream sink that counts beats and tlast-delimited lines.
//
// Ports:
//   aclk, aclk_reset_n         clock, asynchronous active-low reset
//   cmd_*                      command handshake, direction, address, data, strobes
//   rsp_valid/rsp_rdata/rsp_resp  one-cycle completion pulse, read data, response
//                              (2'b11 marks a timeout)
//   m                          AXI4-Lite master bus (axil_host_master_if.master)
//   gpio_wr/gpio_wdata/gpio_out  GPIO output register
//   gpio_in/gpio_in_sync/gpio_in_rise/gpio_rise_clr  synchronized inputs with
//                              sticky rising-edge flags
//   s_axis_*                   stream sink; axis_en gates tready
//   axis_beat_cnt/axis_line_cnt/axis_last_user/axis_cnt_clr  stream statistics
module axil_host_master #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 11,
  parameter int NUMB_INPUT_IO   = 1,
  parameter int NUMB_OUTPUT_IO  = 3,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_USER_WIDTH = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       aclk,
  input  logic                       aclk_reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]    cmd_wstrb,
  output logic                       rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic [1:0]                 rsp_resp,
  axil_host_master_if.master         m,
  input  logic                       gpio_wr,
  input  logic [NUMB_OUTPUT_IO-1:0]  gpio_wdata,
  output logic [NUMB_OUTPUT_IO-1:0]  gpio_out,
  input  logic [NUMB_INPUT_IO-1:0]   gpio_in,
  output logic [NUMB_INPUT_IO-1:0]   gpio_in_sync,
  output logic [NUMB_INPUT_IO-1:0]   gpio_in_rise,
  input  logic [NUMB_INPUT_IO-1:0]   gpio_rise_clr,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
  input  logic                       axis_en,
  output logic [31:0]                axis_beat_cnt,
  output logic [31:0]                axis_line_cnt,
  output logic [AXIS_USER_WIDTH-1:0] axis_last_user,
  input  logic                       axis_cnt_clr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t                state, state_nx;
  logic                  aw_pend, w_pend;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [TMO_W-1:0]      tmo_cnt;

  logic cmd_acc, aw_hs, w_hs, b_hs, ar_hs, r_hs, tmo_hit;

  // cmd_ready stays low through the response cycle so a new command can only
  // be taken the cycle after rsp_valid.
  assign cmd_acc = (state == IDLE) && !rsp_valid && cmd_valid;
  assign aw_hs   = (state == WR) && aw_pend && m.awready;
  assign w_hs    = (state == WR) && w_pend && m.wready;
  assign b_hs    = (state == WR_RESP) && m.bvalid;
  assign ar_hs   = (state == RD_ADDR) && m.arready;
  assign r_hs    = (state == RD_DATA) && m.rvalid;
  // A real completion in the last allowed cycle beats the timeout.
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST) && !b_hs && !r_hs;

  assign m.awprot = 3'b000;
  assign m.arprot = 3'b000;
  assign m.awaddr = addr_q;
  assign m.araddr = addr_q;
  assign m.wdata  = wdata_q;
  assign m.wstrb  = strb_q;

  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) state <= IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    m.awvalid = 1'b0;
    m.wvalid  = 1'b0;
    m.bready  = 1'b0;
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rsp_valid;
        if (cmd_acc) state_nx = cmd_write ? WR : RD_ADDR;
      end
      WR: begin
        m.awvalid = aw_pend;
        m.wvalid  = w_pend;
        // AW and W may finish in either order; move on once both are done.
        if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) state_nx = WR_RESP;
      end
      WR_RESP: begin
        m.bready = 1'b1;
        if (b_hs) state_nx = IDLE;
      end
      RD_ADDR: begin
        m.arvalid = 1'b1;
        if (ar_hs) state_nx = RD_DATA;
      end
      RD_DATA: begin
        m.rready = 1'b1;
        if (r_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (tmo_hit) state_nx = IDLE;
  end

  // Transaction control and response registers.
  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      tmo_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_resp  <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (cmd_acc) begin
        aw_pend <= cmd_write;
        w_pend  <= cmd_write;
        tmo_cnt <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
      if (tmo_hit) begin
        aw_pend   <= 1'b0;
        w_pend    <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_resp  <= 2'b11;
        rsp_rdata <= '0;
      end else if (b_hs) begin
        rsp_valid <= 1'b1;
        rsp_resp  <= m.bresp;
      end else if (r_hs) begin
        rsp_valid <= 1'b1;
        rsp_resp  <= m.rresp;
        rsp_rdata <= m.rdata;
      end
    end
  end

  // Command payload only matters while a valid is up, so it carries no reset.
  always_ff @(posedge aclk) begin
    if (cmd_acc) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      strb_q  <= cmd_wstrb;
    end
  end

  // GPIO: output register, 2-flop input synchronizer, sticky rise flags.
  logic [NUMB_INPUT_IO-1:0] sync_p0, sync_p1, rise_q;

  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      gpio_out <= '0;
      sync_p0  <= '0;
      sync_p1  <= '0;
      rise_q   <= '0;
    end else begin
      if (gpio_wr) gpio_out <= gpio_wdata;
      sync_p0 <= gpio_in;
      sync_p1 <= sync_p0;
      // The flag rises on the same edge the synchronized input goes high; a
      // set in the same cycle as a clear wins.
      rise_q  <= (rise_q & ~gpio_rise_clr) | (sync_p0 & ~sync_p1);
    end
  end

  assign gpio_in_sync = sync_p1;
  assign gpio_in_rise = rise_q;

  // Stream sink: payload is consumed but not stored.
  logic unused_tdata;
  logic axis_acc;

  assign unused_tdata = ^s_axis_tdata;
  assign axis_acc     = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      s_axis_tready  <= 1'b0;
      axis_beat_cnt  <= '0;
      axis_line_cnt  <= '0;
      axis_last_user <= '0;
    end else begin
      s_axis_tready <= axis_en;
      if (axis_cnt_clr) begin
        axis_beat_cnt <= '0;
        axis_line_cnt <= '0;
      end else if (axis_acc) begin
        axis_beat_cnt <= axis_beat_cnt + 32'd1;
        if (s_axis_tlast) axis_line_cnt <= axis_line_cnt + 32'd1;
      end
      if (axis_acc) axis_last_user <= s_axis_tuser;
    end
  end

endmodule

// File: tb/tb_axil_host_master.sv
module tb_axil_host_master;
  localparam int TMO = 64;
  localparam int BIG = 100000;

  logic        aclk = 1'b0;
  logic        aclk_reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [10:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        gpio_wr;
  logic [2:0]  gpio_wdata, gpio_out;
  logic [0:0]  gpio_in, gpio_in_sync, gpio_in_rise, gpio_rise_clr;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [63:0] s_axis_tdata;
  logic [3:0]  s_axis_tuser, axis_last_user;
  logic        axis_en, axis_cnt_clr;
  logic [31:0] axis_beat_cnt, axis_line_cnt;

  axil_host_master_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus ();

  axil_host_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .aclk_reset_n(aclk_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m(bus.master),
    .gpio_wr(gpio_wr), .gpio_wdata(gpio_wdata), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .gpio_in_sync(gpio_in_sync), .gpio_in_rise(gpio_in_rise),
    .gpio_rise_clr(gpio_rise_clr),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .axis_en(axis_en), .axis_beat_cnt(axis_beat_cnt), .axis_line_cnt(axis_line_cnt),
    .axis_last_user(axis_last_user), .axis_cnt_clr(axis_cnt_clr)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int pcyc = 0;
  always @(posedge aclk) pcyc <= pcyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave behaviour knobs
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
  logic [31:0] rdata_v = '0;

  initial begin
    int n;
    n = 0; bus.awready = 1'b0;
    forever begin
      @(negedge aclk);
      if (bus.awready) begin bus.awready = 1'b0; n = 0; end
      else if (bus.awvalid) begin if (n >= aw_dly) bus.awready = 1'b1; else n++; end
      else n = 0;
    end
  end

  initial begin
    int n;
    n = 0; bus.wready = 1'b0;
    forever begin
      @(negedge aclk);
      if (bus.wready) begin bus.wready = 1'b0; n = 0; end
      else if (bus.wvalid) begin if (n >= w_dly) bus.wready = 1'b1; else n++; end
      else n = 0;
    end
  end

  initial begin
    int n;
    n = 0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (bus.bvalid) begin bus.bvalid = 1'b0; n = 0; end
      else if (bus.bready) begin
        if (n >= b_dly) begin bus.bvalid = 1'b1; bus.bresp = bresp_v; end else n++;
      end else n = 0;
    end
  end

  initial begin
    int n;
    n = 0; bus.arready = 1'b0;
    forever begin
      @(negedge aclk);
      if (bus.arready) begin bus.arready = 1'b0; n = 0; end
      else if (bus.arvalid) begin if (n >= ar_dly) bus.arready = 1'b1; else n++; end
      else n = 0;
    end
  end

  initial begin
    int n;
    n = 0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (bus.rvalid) begin bus.rvalid = 1'b0; n = 0; end
      else if (bus.rready) begin
        if (n >= r_dly) begin bus.rvalid = 1'b1; bus.rdata = rdata_v; bus.rresp = rresp_v; end
        else n++;
      end else n = 0;
    end
  end

  // Scoreboard of expected responses
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        chk_rdata;
    int          lat;
    int          send_cyc;
  } sb_t;
  sb_t sb_q[$];
  logic ready_pending = 1'b0;

  always @(negedge aclk) begin
    if (ready_pending) begin
      chk("cmd_ready_after_rsp", cmd_ready, 1'b1);
      ready_pending = 1'b0;
    end
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("rsp_resp", rsp_resp, e.resp);
        if (e.chk_rdata) chk("rsp_rdata", rsp_rdata, e.rdata);
        if (e.lat != 0) chk("latency", pcyc - e.send_cyc, e.lat);
        chk("bus_idle_at_rsp", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
        chk("cmd_ready_during_rsp", cmd_ready, 1'b0);
        ready_pending = 1'b1;
      end
    end
  end

  typedef struct {
    logic wr; logic [10:0] addr; logic [31:0] wdata; logic [3:0] strb;
    int aw_dly; int w_dly; int b_dly; int ar_dly; int r_dly;
    logic [1:0] bresp; logic [31:0] rdata; logic [1:0] rresp;
    logic [1:0] exp_resp; logic [31:0] exp_rdata; int lat;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [10:0] addr, logic [31:0] wdata, logic [3:0] strb,
                              int awd, int wd, int bd, int ard, int rd,
                              logic [1:0] bresp, logic [31:0] rdata, logic [1:0] rresp,
                              logic [1:0] eresp, logic [31:0] erdata, int lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
    v.bresp = bresp; v.rdata = rdata; v.rresp = rresp;
    v.exp_resp = eresp; v.exp_rdata = erdata; v.lat = lat;
    return v;
  endfunction

  task automatic send_cmd(input vec_t v);
    int w;
    sb_t e;
    aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly; ar_dly = v.ar_dly; r_dly = v.r_dly;
    bresp_v = v.bresp; rdata_v = v.rdata; rresp_v = v.rresp;
    @(negedge aclk);
    w = 0;
    while (!cmd_ready && w < 100) begin @(negedge aclk); w++; end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.strb;
    e.resp = v.exp_resp; e.rdata = v.exp_rdata;
    e.chk_rdata = !v.wr || (v.exp_resp == 2'b11);
    e.lat = v.lat; e.send_cyc = pcyc;
    sb_q.push_back(e);
    @(negedge aclk);
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", cmd_ready, 1'b0);
  endtask

  task automatic wait_rsp();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 300) begin @(negedge aclk); w++; end
    chk("rsp_arrived", sb_q.size(), 0);
    @(negedge aclk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];
  vec_t v;

  initial begin
    vecs[0] = mk(1, 11'h020, 32'h11223344, 4'hF, 0, 0, 0, 0, 0, 2'b00, '0, 2'b00, 2'b00, '0, 3);
    vecs[1] = mk(0, 11'h000, '0, 4'h0, 0, 0, 0, 0, 3, 2'b00, 32'h00585300, 2'b00, 2'b00, 32'h00585300, 6);
    vecs[2] = mk(1, 11'h004, 32'hA5A5A5A5, 4'h3, 0, 0, 0, 0, 0, 2'b10, '0, 2'b00, 2'b10, '0, 3);
    vecs[3] = mk(0, 11'h7FC, '0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFE0123, 2'b01, 2'b01, 32'hCAFE0123, 3);
    vecs[4] = mk(1, 11'h008, 32'h0BADF00D, 4'h8, 0, 3, 1, 0, 0, 2'b00, '0, 2'b00, 2'b00, '0, 7);
    vecs[5] = mk(0, 11'h00C, '0, 4'h0, 0, 0, 0, BIG, 0, 2'b00, 32'hFFFFFFFF, 2'b00, 2'b11, 32'h0, TMO + 1);
    vecs[6] = mk(1, 11'h010, 32'h55AA55AA, 4'hF, 0, 0, BIG, 0, 0, 2'b00, '0, 2'b00, 2'b11, 32'h0, TMO + 1);
    vecs[7] = mk(0, 11'h100, '0, 4'h0, 0, 0, 0, 1, 0, 2'b00, 32'h12345678, 2'b00, 2'b00, 32'h12345678, 4);

    aclk_reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    gpio_wr = 1'b0; gpio_wdata = '0; gpio_in = '0; gpio_rise_clr = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    axis_en = 1'b0; axis_cnt_clr = 1'b0;
    repeat (3) @(negedge aclk);

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp", {rsp_valid, rsp_resp, rsp_rdata}, '0);
    chk("rst_bus", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    chk("rst_prot", {bus.awprot, bus.arprot}, 6'b0);
    chk("rst_gpio", {gpio_out, gpio_in_sync, gpio_in_rise}, '0);
    chk("rst_axis", {s_axis_tready, axis_beat_cnt, axis_line_cnt, axis_last_user}, '0);
    aclk_reset_n = 1'b1;
    @(negedge aclk);

    // Directed write: AW delayed by 2 cycles, W immediate
    v = mk(1, 11'h010, 32'hDEADBEEF, 4'hF, 2, 0, 0, 0, 0, 2'b00, '0, 2'b00, 2'b00, '0, 5);
    send_cmd(v);
    chk("wr_aw_w_both", {bus.awvalid, bus.wvalid}, 2'b11);
    chk("wr_payload", {bus.awaddr, bus.wdata, bus.wstrb}, {11'h010, 32'hDEADBEEF, 4'hF});
    @(negedge aclk);
    chk("wr_w_dropped_first", {bus.awvalid, bus.wvalid}, 2'b10);
    @(negedge aclk);
    chk("wr_aw_still_up", {bus.awvalid, bus.wvalid}, 2'b10);
    @(negedge aclk);
    chk("wr_resp_phase", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
    wait_rsp();

    // Table-driven transactions
    for (int i = 0; i < 8; i++) begin
      send_cmd(vecs[i]);
      if (vecs[i].wr)
        chk("aw_payload", {bus.awvalid, bus.awaddr, bus.wdata, bus.wstrb},
            {1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].strb});
      else
        chk("ar_payload", {bus.arvalid, bus.araddr}, {1'b1, vecs[i].addr});
      wait_rsp();
    end

    // Reset while waiting for the write response
    v = mk(1, 11'h014, 32'h01020304, 4'hF, 0, 0, BIG, 0, 0, 2'b00, '0, 2'b00, 2'b00, '0, 0);
    send_cmd(v);
    begin
      int w;
      w = 0;
      while (!bus.bready && w < 20) begin @(negedge aclk); w++; end
      chk("reach_wr_resp", bus.bready, 1'b1);
    end
    void'(sb_q.pop_back());
    aclk_reset_n = 1'b0;
    #1;
    chk("rst_mid_bus", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    chk("rst_mid_rsp", rsp_valid, 1'b0);
    repeat (2) @(negedge aclk);
    aclk_reset_n = 1'b1;
    b_dly = 0;
    repeat (4) @(negedge aclk);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
    send_cmd(vecs[3]);
    wait_rsp();

    // GPIO output register
    gpio_wr = 1'b1; gpio_wdata = 3'b101;
    #1 chk("gpio_out_not_yet", gpio_out, 3'b000);
    @(negedge aclk);
    gpio_wr = 1'b0; gpio_wdata = 3'b010;
    chk("gpio_out_load", gpio_out, 3'b101);
    @(negedge aclk);
    chk("gpio_out_hold", gpio_out, 3'b101);

    // GPIO input synchronizer and rise flag
    gpio_in = 1'b1;
    @(negedge aclk);
    chk("gpio_sync_1cyc", {gpio_in_sync, gpio_in_rise}, 2'b00);
    @(negedge aclk);
    chk("gpio_sync_2cyc", {gpio_in_sync, gpio_in_rise}, 2'b11);
    gpio_in = 1'b0;
    gpio_rise_clr = 1'b1;
    @(negedge aclk);
    gpio_rise_clr = 1'b0;
    chk("gpio_rise_clear", gpio_in_rise, 1'b0);
    repeat (3) @(negedge aclk);
    chk("gpio_sync_low", {gpio_in_sync, gpio_in_rise}, 2'b00);
    gpio_in = 1'b1;
    @(negedge aclk);
    gpio_rise_clr = 1'b1;
    @(negedge aclk);
    gpio_rise_clr = 1'b0;
    chk("gpio_set_beats_clr", {gpio_in_sync, gpio_in_rise}, 2'b11);
    gpio_in = 1'b0;

    // Stream sink: 4 lines of 8 beats
    axis_en = 1'b1;
    #1 chk("tready_registered", s_axis_tready, 1'b0);
    @(negedge aclk);
    chk("tready_on", s_axis_tready, 1'b1);
    for (int b = 0; b < 32; b++) begin
      if (b == 13) begin s_axis_tvalid = 1'b0; @(negedge aclk); end
      s_axis_tvalid = 1'b1;
      s_axis_tdata = {$urandom, $urandom};
      s_axis_tlast = (b % 8 == 7);
      s_axis_tuser = (b == 31) ? 4'b0010 : 4'hA;
      @(negedge aclk);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    @(negedge aclk);
    chk("axis_counts", {axis_beat_cnt, axis_line_cnt}, {32'd32, 32'd4});
    chk("axis_last_user", axis_last_user, 4'd2);

    axis_en = 1'b0;
    @(negedge aclk);
    chk("tready_off", s_axis_tready, 1'b0);
    for (int k = 0; k < 6; k++) begin
      s_axis_tvalid = k[0];
      s_axis_tlast = 1'b1;
      s_axis_tuser = 4'h7;
      @(negedge aclk);
    end
    s_axis_tvalid = 1'b0;
    chk("axis_disabled_hold", {axis_beat_cnt, axis_line_cnt, axis_last_user}, {32'd32, 32'd4, 4'd2});

    axis_en = 1'b1;
    @(negedge aclk);
    axis_cnt_clr = 1'b1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tuser = 4'h5;
    @(negedge aclk);
    axis_cnt_clr = 1'b0;
    chk("axis_clr_priority", {axis_beat_cnt, axis_line_cnt}, 64'd0);
    @(negedge aclk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("axis_after_clr", {axis_beat_cnt, axis_line_cnt, axis_last_user}, {32'd1, 32'd1, 4'h5});

    repeat (3) @(negedge aclk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
